// File: rtl/icache_axi_refill.sv
// Instruction-cache line refill engine: one 16-byte line per request, fetched as a 4-beat AXI4 INCR read.
// Latency: request to ret_valid is 6 cycles with a zero-wait slave (AR at +1, beats at +2..+5).
// Backpressure: holds AR until arready and absorbs R gaps; accepts a new request only in IDLE.
module icache_axi_refill #(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [127:0] ret_data,
  output logic         ret_err,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  typedef enum logic [1:0] {IDLE, AR, R, RET} state_t;

  state_t           state;
  logic [31:0]      addr_q;
  logic [3:0][31:0] line_q;
  logic [1:0]       cnt_q;
  logic             full_q;
  logic             err_q;
  logic             unused_bits;

  assign unused_bits = ^{rid, rd_addr[3:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      line_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            addr_q <= {rd_addr[31:4], 4'h0};
            line_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
            state  <= AR;
          end
        end
        AR: begin
          if (arready) state <= R;
        end
        R: begin
          if (rvalid) begin
            // full_q marks that word 3 is written, so surplus beats land nowhere
            if (!full_q) line_q[cnt_q] <= rdata;
            if (cnt_q == 2'd3) full_q <= 1'b1;
            else               cnt_q  <= cnt_q + 2'd1;
            err_q <= err_q | (rresp != 2'b00);
            if (rlast) state <= RET;
          end
        end
        RET:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_rdy    = (state == IDLE) && !reset;
  assign arvalid   = (state == AR);
  assign rready    = (state == R);
  assign ret_valid = (state == RET);
  assign ret_data  = line_q;
  assign ret_err   = err_q;
  assign araddr    = addr_q;
  assign arid      = ARID_VAL;
  assign arlen     = 8'd3;
  assign arsize    = 3'd2;
  assign arburst   = 2'b01;

endmodule
